// File: rtl/tx_fifo_pkg.sv
// Shared transmit-path types and default geometry for the tx FIFO.
// The UART transmitter and the MMIO decoder reuse tx_word_t.
package tx_fifo_pkg;
  localparam int TX_FIFO_WIDTH_DEF  = 8;
  localparam int TX_FIFO_ADDR_W_DEF = 10;

  typedef logic [TX_FIFO_WIDTH_DEF-1:0] tx_word_t;
endpackage

// File: rtl/tx_fifo_mem.sv
// Dual-port storage: synchronous write, asynchronous read for LUT-RAM mapping.
// The write lands on the clock edge, and the read path has no register.
module tx_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0]  rd
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];
endmodule

// File: rtl/tx_fifo.sv
// Circular tx queue: a push is readable one cycle later (zero cycles with TX_FIFO_BYPASS_EN).
// A push while full is dropped and sets sticky overflow. Drain uses valid/ready, one word per cycle.
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter int WIDTH  = TX_FIFO_WIDTH_DEF,
  parameter int ADDR_W = TX_FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [WIDTH-1:0]  wd,
  output logic              full,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [ADDR_W:0]  wp;
  logic [ADDR_W:0]  rp;
  logic [WIDTH-1:0] mem_rd;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wp == rp);
  assign full  = (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]) && (wp[ADDR_W] != rp[ADDR_W]);
  assign count = wp - rp;

`ifdef TX_FIFO_BYPASS_EN
  // On an empty queue the incoming word is presented directly. It is stored
  // only if the transmitter does not take it in the same cycle.
  logic fwd;
  assign fwd      = empty && we && rd_ready;
  assign rd_valid = !empty || we;
  assign rd_data  = empty ? wd : mem_rd;
  assign push     = we && !full && !fwd;
`else
  assign rd_valid = !empty;
  assign rd_data  = mem_rd;
  assign push     = we && !full;
`endif
  assign pop = !empty && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      // full is sampled at the start of the cycle, so a push+pop while full still drops.
      if (we && full) overflow <= 1'b1;
    end
  end

  tx_fifo_mem #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk (clk),
    .we  (push),
    .wa  (wp[ADDR_W-1:0]),
    .wd  (wd),
    .ra  (rp[ADDR_W-1:0]),
    .rd  (mem_rd)
  );
endmodule

// File: tb/tb_tx_fifo.sv
// Directed and random checks of tx_fifo (ADDR_W=2) against a queue-based reference model.
module tb_tx_fifo;
  import tx_fifo_pkg::*;

  localparam int W     = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 2**AW;
`ifdef TX_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [W-1:0]  wd;
  logic          full;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_ready;
  logic [AW:0]   count;
  logic          overflow;

  tx_fifo #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wd       (wd),
    .full     (full),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  tx_word_t q[$];
  bit       m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at the falling edge, then advance the model.
  task automatic cycle(input logic r, input logic w, input logic [W-1:0] d, input logic rdy);
    logic     exp_vld;
    logic     full0;
    tx_word_t tmp;
    rst = r; we = w; wd = d; rd_ready = rdy;
    @(negedge clk);
    exp_vld = (q.size() > 0) || (BYP && w);
    chk("count",    32'(count),    32'(q.size()));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (exp_vld) chk("rd_data", 32'(rd_data), 32'((q.size() > 0) ? q[0] : d));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (!(BYP && q.size() == 0 && w && rdy)) begin
      full0 = (q.size() == DEPTH);
      if (q.size() > 0 && rdy) tmp = q.pop_front();
      if (w) begin
        if (full0) m_ovf = 1'b1;
        else       q.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wd = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); m_ovf = 1'b0;
    chk("rst_count",    32'(count),    0);
    chk("rst_full",     32'(full),     0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Basic push then in-order drain.
    cycle(0, 1, 8'h41, 0);
    cycle(0, 1, 8'h42, 0);
    cycle(0, 1, 8'h43, 0);
    chk("p3_count", 32'(count), 3);
    chk("p3_vld",   32'(rd_valid), 1);
    chk("p3_head",  32'(rd_data), 32'h41);
    cycle(0, 0, 8'h00, 1);
    chk("d1_head", 32'(rd_data), 32'h42);
    cycle(0, 0, 8'h00, 1);
    chk("d2_head", 32'(rd_data), 32'h43);
    cycle(0, 0, 8'h00, 1);
    chk("d3_count", 32'(count), 0);
    chk("d3_vld",   32'(rd_valid), 0);

    // Fill, overflow, and drain order excluding the dropped word.
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(8'h10 + i), 0);
    chk("fill_full", 32'(full), 1);
    cycle(0, 1, 8'h55, 0);
    chk("ovf_set",   32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'h00, 1);
    chk("ovf_drained", 32'(count), 0);
    chk("ovf_sticky",  32'(overflow), 1);

    // Prefill two, then ten back-to-back push+pop cycles across the wrap.
    cycle(0, 1, 8'h60, 0);
    cycle(0, 1, 8'h61, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 8'(8'h70 + i), 1);
      chk("pp_count", 32'(count), 2);
    end
    for (int i = 0; i < 2; i++) cycle(0, 0, 8'h00, 1);

    // Full with simultaneous push and pop: pop wins, push dropped.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(8'h80 + i), 0);
    cycle(0, 1, 8'h99, 1);
    chk("fpp_count", 32'(count), 3);
    chk("fpp_ovf",   32'(overflow), 1);
    chk("fpp_head",  32'(rd_data), 32'h81);

    // Empty push with rd_ready high, then reset in the middle of a drain.
    cycle(1, 0, 8'h00, 0);
    chk("rst2_ovf", 32'(overflow), 0);
    cycle(0, 1, 8'hA5, 1);
    if (BYP) begin
      chk("byp_count", 32'(count), 0);
    end else begin
      chk("nobyp_vld",  32'(rd_valid), 1);
      chk("nobyp_data", 32'(rd_data), 32'hA5);
    end
    cycle(0, 1, 8'hB0, 0);
    cycle(0, 1, 8'hB1, 0);
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_vld",   32'(rd_valid), 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
            8'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
